// File: rtl/mmu_pkg.sv
// Shared definitions for the matrix-unit feed sequencer: counter width and FSM encoding.
package mmu_pkg;

  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage : mmu_pkg

// File: rtl/step_dec.sv
// Combinational a - b (b is one bit) as a ripple of full adders: a + {W{b}} is a - b mod 2**W.
module step_dec
  import mmu_pkg::*;
#(
  parameter int CNT_W = mmu_pkg::CNT_W
) (
  input  logic [CNT_W-1:0] a_i,
  input  logic             b_i,
  output logic [CNT_W-1:0] y_o
);

  logic [CNT_W:0] carry;

  assign carry[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 0; gi < CNT_W; gi++) begin : g_fa
      // Subtrahend of 1 is all-ones in two's complement, so every adder sees b_i.
      assign y_o[gi]       = a_i[gi] ^ b_i ^ carry[gi];
      assign carry[gi + 1] = (a_i[gi] & b_i) | (carry[gi] & (a_i[gi] ^ b_i));
    end
  endgenerate

endmodule : step_dec

// File: rtl/mmu_feed_sequencer.sv
// Row-feed sequencer: issues descending row indices for a job, drains the array, then pulses done.
module mmu_feed_sequencer
  import mmu_pkg::*;
#(
  parameter int CNT_W     = mmu_pkg::CNT_W,
  parameter int DRAIN_CYC = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [CNT_W-1:0] len_i,
  input  logic             stall_i,
  input  logic             abort_i,
  output logic             ready_o,
  output logic             feed_valid_o,
  output logic [CNT_W-1:0] feed_idx_o,
  output logic             drain_o,
  output logic             done_o
);

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] DRAIN_LEN = CNT_W'(DRAIN_CYC);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             step_b;
  logic [CNT_W-1:0] dec_out;

  // Only active counting states step, and never while stalled, so cnt is never stepped at 0.
  assign step_b = ((state_q == ST_FEED) || (state_q == ST_DRAIN)) && !stall_i;

  step_dec #(.CNT_W(CNT_W)) u_step_dec (
    .a_i (cnt_q),
    .b_i (step_b),
    .y_o (dec_out)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (len_i != '0) begin
            state_d = ST_FEED;
            cnt_d   = len_i;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_FEED: begin
        cnt_d = dec_out;
        if (!stall_i && (cnt_q == CNT_ONE)) begin
          if (DRAIN_CYC == 0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_DRAIN;
            cnt_d   = DRAIN_LEN;
          end
        end
      end
      ST_DRAIN: begin
        cnt_d = dec_out;
        if (!stall_i && (cnt_q == CNT_ONE)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    // Abort overrides every transition, including a start arriving in the same cycle.
    if (abort_i) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ready_o      = (state_q == ST_IDLE);
  assign feed_valid_o = (state_q == ST_FEED) && !stall_i;
  assign feed_idx_o   = (state_q == ST_FEED) ? (cnt_q - CNT_ONE) : '0;
  assign drain_o      = (state_q == ST_DRAIN);
  assign done_o       = (state_q == ST_DONE);

endmodule : mmu_feed_sequencer
